// File: rtl/sd_cmd_seq.sv
// SD-card command sequencer: drives the byte-wide SPI engine through lead-in, 6-byte frame,
// R1 polling and an optional trailer byte, with chip-select control.
module sd_cmd_seq #(
  parameter int unsigned POLL_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd,
  input  logic [31:0] arg,
  input  logic [6:0]  crc,
  input  logic        keep_cs,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        cs_n,
  output logic        spi_wr,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_busy
);

  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);
  localparam logic [2:0] LAST_IDX  = 3'd5;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_PRE,
    PH_SEND,
    PH_POLL,
    PH_POST
  } phase_t;

  typedef enum logic [1:0] {
    SUB_ISSUE,
    SUB_ARM,
    SUB_WAIT
  } sub_t;

  phase_t      phase;
  sub_t        sub;
  logic [2:0]  idx;
  logic [7:0]  poll_cnt;
  logic [5:0]  cmd_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic        keep_q;

  logic [7:0]  tx_byte_c;
  logic        byte_done_c;
  logic        poll_exit_c;

  // Byte to send for the current phase; only SEND carries frame data.
  always_comb begin
    tx_byte_c = 8'hFF;
    if (phase == PH_SEND) begin
      case (idx)
        3'd0:    tx_byte_c = {2'b01, cmd_q};
        3'd1:    tx_byte_c = arg_q[31:24];
        3'd2:    tx_byte_c = arg_q[23:16];
        3'd3:    tx_byte_c = arg_q[15:8];
        3'd4:    tx_byte_c = arg_q[7:0];
        3'd5:    tx_byte_c = {crc_q, 1'b1};
        default: tx_byte_c = 8'hFF;
      endcase
    end
  end

  // A byte completes when the engine drops busy while we wait on it.
  always_comb begin
    byte_done_c = (phase != PH_IDLE) && (sub == SUB_WAIT) && !spi_busy;
    poll_exit_c = byte_done_c && (phase == PH_POLL) &&
                  (!spi_rx[7] || (poll_cnt == POLL_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= PH_IDLE;
      sub      <= SUB_ISSUE;
      idx      <= 3'd0;
      poll_cnt <= 8'd0;
      cmd_q    <= 6'd0;
      arg_q    <= 32'd0;
      crc_q    <= 7'd0;
      keep_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r1       <= 8'hFF;
      timeout  <= 1'b0;
      cs_n     <= 1'b1;
      spi_wr   <= 1'b0;
      spi_tx   <= 8'hFF;
    end else begin
      done   <= 1'b0;
      spi_wr <= 1'b0;
      if (phase == PH_IDLE) begin
        if (start) begin
          cmd_q    <= cmd;
          arg_q    <= arg;
          crc_q    <= crc;
          keep_q   <= keep_cs;
          timeout  <= 1'b0;
          busy     <= 1'b1;
          cs_n     <= 1'b0;
          idx      <= 3'd0;
          poll_cnt <= 8'd0;
          sub      <= SUB_ISSUE;
          phase    <= PH_PRE;
        end
      end else begin
        case (sub)
          SUB_ISSUE: begin
            // The engine may still be finishing a byte from before a reset.
            if (!spi_busy) begin
              spi_wr <= 1'b1;
              spi_tx <= tx_byte_c;
              sub    <= SUB_ARM;
            end
          end
          SUB_ARM:  sub <= SUB_WAIT;
          SUB_WAIT: if (byte_done_c) sub <= SUB_ISSUE;
          default:  sub <= SUB_ISSUE;
        endcase

        if (byte_done_c) begin
          case (phase)
            PH_PRE:  phase <= PH_SEND;
            PH_SEND: begin
              if (idx == LAST_IDX) phase <= PH_POLL;
              else                 idx   <= idx + 3'd1;
            end
            PH_POLL: begin
              if (poll_exit_c) begin
                if (!spi_rx[7]) begin
                  r1 <= spi_rx;
                end else begin
                  r1      <= 8'hFF;
                  timeout <= 1'b1;
                end
                if (keep_q) begin
                  phase <= PH_IDLE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  phase <= PH_POST;
                  cs_n  <= 1'b1;
                end
              end else begin
                poll_cnt <= poll_cnt + 8'd1;
              end
            end
            PH_POST: begin
              phase <= PH_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
            default: phase <= PH_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Scoreboard bench for sd_cmd_seq with a behavioural SPI engine and a queue-based reference model.
module tb_sd_cmd_seq;

  localparam int unsigned POLL_MAX    = 8;
  localparam int          TIMEOUT_CYC = 4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  cmd = 6'd0;
  logic [31:0] arg = 32'd0;
  logic [6:0]  crc = 7'd0;
  logic        keep_cs = 1'b0;
  logic        busy, done, timeout, cs_n, spi_wr;
  logic [7:0]  r1, spi_tx;
  logic [7:0]  spi_rx = 8'hFF;
  logic        spi_busy;
  logic        eng_busy = 1'b0;
  logic        ext_busy = 1'b0;

  assign spi_busy = eng_busy | ext_busy;

  sd_cmd_seq #(.POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .arg(arg), .crc(crc),
    .keep_cs(keep_cs), .busy(busy), .done(done), .r1(r1), .timeout(timeout),
    .cs_n(cs_n), .spi_wr(spi_wr), .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_busy(spi_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] tx;
    logic       cs_n;
  } txe_t;

  typedef struct packed {
    logic [7:0] r1;
    logic       to;
    logic       keep;
    logic [7:0] n;
  } rsp_t;

  txe_t       exp_tx_q[$];
  rsp_t       exp_rsp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] script[$];

  int errors = 0;
  int checks = 0;
  int tx_seen = 0;
  int unsigned min_bt = 1;
  int unsigned max_bt = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // SPI engine: busy rises the cycle after spi_wr, falls after a byte time, then rx is valid.
  logic        pend = 1'b0;
  int unsigned cnt = 0;
  logic [7:0]  cur_rx = 8'hFF;
  always @(negedge clk) begin
    if (spi_wr) begin
      pend   = 1'b1;
      cur_rx = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
    end else if (pend) begin
      pend     = 1'b0;
      eng_busy = 1'b1;
      cnt      = $urandom_range(max_bt, min_bt);
    end else if (eng_busy) begin
      if (cnt <= 1) begin
        eng_busy = 1'b0;
        spi_rx   = cur_rx;
      end else begin
        cnt--;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a byte or signals done.
  logic prev_wr = 1'b0;
  logic prev_done = 1'b0;
  int   tx_cmd = 0;
  always @(negedge clk) begin
    txe_t e;
    rsp_t r;
    if (reset) begin
      tx_cmd    = 0;
      prev_wr   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (spi_wr) begin
        tx_seen++;
        tx_cmd++;
        chk("wr_back_to_back", 32'(prev_wr), 32'd0);
        chk("wr_while_spi_busy", 32'(spi_busy), 32'd0);
        if (exp_tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx actual=%0h required=none", spi_tx);
        end else begin
          e = exp_tx_q.pop_front();
          chk("tx_byte", 32'(spi_tx), 32'(e.tx));
          chk("cs_n_at_tx", 32'(cs_n), 32'(e.cs_n));
        end
      end
      if (done) begin
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
        if (exp_rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          r = exp_rsp_q.pop_front();
          chk("r1", 32'(r1), 32'(r.r1));
          chk("timeout", 32'(timeout), 32'(r.to));
          chk("cs_n_at_done", 32'(cs_n), 32'(!r.keep));
          chk("tx_count", 32'(tx_cmd), 32'(r.n));
        end
        tx_cmd = 0;
      end
      prev_wr   = spi_wr;
      prev_done = done;
    end
  end

  // Reference model: derive bytes on the wire and the response from the rx script.
  task automatic push_cmd(input logic [5:0] c, input logic [31:0] a, input logic [6:0] cr,
                          input logic k);
    logic [7:0] fr [6];
    logic [7:0] rx;
    logic [7:0] rsp;
    logic       found;
    int         np;
    int         n;
    int         sz;
    sz    = script.size();
    fr[0] = {2'b01, c};
    fr[1] = a[31:24];
    fr[2] = a[23:16];
    fr[3] = a[15:8];
    fr[4] = a[7:0];
    fr[5] = {cr, 1'b1};
    exp_tx_q.push_back('{tx: 8'hFF, cs_n: 1'b0});
    for (int i = 0; i < 6; i++) exp_tx_q.push_back('{tx: fr[i], cs_n: 1'b0});
    found = 1'b0;
    rsp   = 8'hFF;
    np    = 0;
    for (int i = 0; i < int'(POLL_MAX); i++) begin
      rx = (7 + i < sz) ? script[7 + i] : 8'hFF;
      np++;
      exp_tx_q.push_back('{tx: 8'hFF, cs_n: 1'b0});
      if (!rx[7]) begin
        rsp   = rx;
        found = 1'b1;
        break;
      end
    end
    n = 7 + np + (k ? 0 : 1);
    if (!k) exp_tx_q.push_back('{tx: 8'hFF, cs_n: 1'b1});
    for (int i = 0; i < n; i++) rx_q.push_back((i < sz) ? script[i] : 8'hFF);
    exp_rsp_q.push_back('{r1: rsp, to: !found, keep: k, n: 8'(n)});
    cmd     = c;
    arg     = a;
    crc     = cr;
    keep_cs = k;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < TIMEOUT_CYC) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=no_done required=done_within_%0d", TIMEOUT_CYC);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_r1"},      32'(r1),      32'hFF);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_cs_n"},    32'(cs_n),    32'd1);
    chk({tag, "_spi_wr"},  32'(spi_wr),  32'd0);
    chk({tag, "_spi_tx"},  32'(spi_tx),  32'hFF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    int np;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // CMD0, response on second poll byte
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    push_cmd(6'd0, 32'd0, 7'h4A, 1'b0);
    pulse_start();
    wait_done();
    @(negedge clk);

    // No response: timeout after POLL_MAX poll bytes
    script.delete();
    push_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b0);
    pulse_start();
    wait_done();
    @(negedge clk);

    // CMD17 with keep_cs, response on first poll byte
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    push_cmd(6'd17, 32'h0000_1234, 7'h2A, 1'b1);
    pulse_start();
    wait_done();
    repeat (3) begin
      @(negedge clk);
      chk("cs_n_held_keep", 32'(cs_n), 32'd0);
    end

    // start while busy is ignored; start in the done cycle is accepted
    script = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFF, 8'hFE, 8'h05};
    push_cmd(6'd55, 32'hDEAD_BEEF, 7'h11, 1'b0);
    pulse_start();
    repeat (4) @(negedge clk);
    cmd   = 6'h3F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_ignored_start", 32'(busy), 32'd1);
    wait_done();
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    push_cmd(6'd41, 32'h4000_0000, 7'h77, 1'b0);
    pulse_start();
    wait_done();
    @(negedge clk);

    // spi_busy held high externally at start
    ext_busy = 1'b1;
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    push_cmd(6'd0, 32'd0, 7'h4A, 1'b0);
    pulse_start();
    repeat (8) begin
      @(negedge clk);
      chk("wr_held_low", 32'(spi_wr), 32'd0);
    end
    ext_busy = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset during SEND byte 3 with a slow engine, then a clean CMD0
    min_bt = 6;
    max_bt = 6;
    script.delete();
    push_cmd(6'd24, 32'h0102_0304, 7'h3C, 1'b0);
    base = tx_seen;
    pulse_start();
    k = 0;
    while (tx_seen < base + 5 && k < TIMEOUT_CYC) begin
      @(negedge clk);
      k++;
    end
    chk("reached_send3", 32'(tx_seen - base), 32'd5);
    @(negedge clk);
    reset = 1'b1;
    exp_tx_q.delete();
    exp_rsp_q.delete();
    rx_q.delete();
    @(negedge clk);
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    push_cmd(6'd0, 32'd0, 7'h4A, 1'b0);
    pulse_start();
    wait_done();
    @(negedge clk);

    // Randomized commands
    repeat (12) begin
      min_bt = 1;
      max_bt = $urandom_range(4, 1);
      script.delete();
      for (int i = 0; i < 7; i++) script.push_back(8'($urandom));
      np = int'($urandom_range(POLL_MAX + 1, 0));
      for (int i = 0; i < np; i++) script.push_back(8'($urandom) | 8'h80);
      script.push_back(8'($urandom) & 8'h7F);
      push_cmd(6'($urandom), $urandom, 7'($urandom), 1'($urandom));
      pulse_start();
      wait_done();
      repeat (1 + $urandom_range(2, 0)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
